// File: rtl/sha3_hasher_arbiter_if.sv
// Bus bundle for sha3_hasher_arbiter: requester, hasher and result signals.
// perf_jobs is present only when SHA3_ARB_PERF_CNT_EN is defined.
interface sha3_hasher_arbiter_if #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned ROW_W = 320
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*ROW_W-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  hsh_valid;
    logic [ROW_W-1:0]      hsh_data;
    logic                  hsh_gimme;
    logic                  hsh_out_valid;
    logic [ROW_W-1:0]      hsh_out_data;
    logic [NREQ-1:0]       res_valid;
    logic [ROW_W-1:0]      res_data;
    logic                  err_orphan;
`ifdef SHA3_ARB_PERF_CNT_EN
    logic [NREQ*32-1:0]    perf_jobs;
`endif

    modport slave (
        input  req_valid, req_data, hsh_gimme, hsh_out_valid, hsh_out_data,
        output req_ready, hsh_valid, hsh_data, res_valid, res_data, err_orphan
`ifdef SHA3_ARB_PERF_CNT_EN
        , output perf_jobs
`endif
    );

    modport master (
        output req_valid, req_data, hsh_gimme, hsh_out_valid, hsh_out_data,
        input  req_ready, hsh_valid, hsh_data, res_valid, res_data, err_orphan
`ifdef SHA3_ARB_PERF_CNT_EN
        , input perf_jobs
`endif
    );
endinterface

// File: rtl/sha3_hasher_arbiter.sv
// Round-robin arbiter feeding 5-beat jobs into one shared hasher, routing results by tag FIFO.
// Optional per-requester completed-job counters with SHA3_ARB_PERF_CNT_EN.
module sha3_hasher_arbiter #(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned ROW_W        = 320,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    sha3_hasher_arbiter_if.slave bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {IDLE, FEED, HOLD} state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    win_q, win_d, rr_q, rr_d;
    logic [2:0]       beat_q, beat_d, rcnt_q, rcnt_d;
    logic [IW-1:0]    tag_q [MAX_INFLIGHT];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]  res_valid_q, res_valid_d;
    logic [ROW_W-1:0] res_data_q, res_data_d;
    logic             err_q, err_d;
    logic             push, pop, fifo_empty, fifo_full, accept, found;
    logic [IW-1:0]    pick, head;
    logic [IW-1:0]    cand [NREQ];

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(MAX_INFLIGHT));
    assign head       = tag_q[rd_q];
    assign pop        = bus.hsh_out_valid && !fifo_empty && (rcnt_q == 3'd4);

    for (genvar k = 0; k < NREQ; k++) begin : g_cand
        assign cand[k] = IW'((32'(rr_q) + 32'(k)) % NREQ);
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && bus.req_valid[cand[k]]) begin
                found = 1'b1;
                pick  = cand[k];
            end
        end
    end

    // HOLD drives the same pass-through as FEED: while stalled req_valid is low so
    // hsh_valid is 0, and the resuming beat is accepted in the cycle it reappears.
    always_comb begin
        state_d       = state_q;
        win_d         = win_q;
        rr_d          = rr_q;
        beat_d        = beat_q;
        push          = 1'b0;
        accept        = 1'b0;
        bus.req_ready = '0;
        bus.hsh_valid = 1'b0;
        bus.hsh_data  = '0;
        unique case (state_q)
            IDLE: begin
                if (found && (!fifo_full || pop)) begin
                    push    = 1'b1;
                    win_d   = pick;
                    rr_d    = IW'((32'(pick) + 32'd1) % NREQ);
                    beat_d  = '0;
                    state_d = FEED;
                end
            end
            FEED, HOLD: begin
                bus.hsh_valid          = bus.req_valid[win_q];
                bus.hsh_data           = bus.req_data[32'(win_q)*ROW_W +: ROW_W];
                bus.req_ready[win_q]   = bus.hsh_gimme;
                accept                 = bus.req_valid[win_q] && bus.hsh_gimme;
                if (accept && beat_q == 3'd4) begin
                    beat_d  = '0;
                    state_d = IDLE;
                end else begin
                    if (accept) beat_d = beat_q + 3'd1;
                    state_d = bus.req_valid[win_q] ? FEED : HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rcnt_d      = rcnt_q;
        res_valid_d = '0;
        res_data_d  = res_data_q;
        err_d       = err_q;
        if (bus.hsh_out_valid) begin
            res_data_d = bus.hsh_out_data;
            if (fifo_empty) begin
                err_d = 1'b1;
            end else begin
                res_valid_d[head] = 1'b1;
                rcnt_d = (rcnt_q == 3'd4) ? 3'd0 : rcnt_q + 3'd1;
            end
        end
    end

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) wr_d = (wr_q == PW'(MAX_INFLIGHT - 1)) ? '0 : wr_q + PW'(1);
        if (pop)  rd_d = (rd_q == PW'(MAX_INFLIGHT - 1)) ? '0 : rd_q + PW'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            win_q       <= '0;
            rr_q        <= '0;
            beat_q      <= '0;
            rcnt_q      <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            res_valid_q <= '0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            rr_q        <= rr_d;
            beat_q      <= beat_d;
            rcnt_q      <= rcnt_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
        end
    end

    // Tag storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (push) tag_q[wr_q] <= pick;
    end

    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.err_orphan = err_q;

`ifdef SHA3_ARB_PERF_CNT_EN
    logic [31:0] perf_q [NREQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREQ; i++) perf_q[i] <= '0;
        end else if (pop) begin
            perf_q[head] <= perf_q[head] + 32'd1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_perf
        assign bus.perf_jobs[g*32 +: 32] = perf_q[g];
    end
`endif
endmodule

// File: tb/tb_sha3_hasher_arbiter.sv
// Self-checking bench for sha3_hasher_arbiter: queue-based job/tag model plus directed pins.
module tb_sha3_hasher_arbiter;
    localparam int NREQ  = 2;
    localparam int ROW_W = 320;
    localparam int MAXI  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sha3_hasher_arbiter_if #(.NREQ(NREQ), .ROW_W(ROW_W)) bus ();

    sha3_hasher_arbiter #(.NREQ(NREQ), .ROW_W(ROW_W), .MAX_INFLIGHT(MAXI)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model: current job owner, beats taken, RR start, queue of outstanding tags.
    int               owner = -1;
    int               beats = 0;
    int               rr = 0;
    int               tags[$];
    int               rbeats = 0;
    logic [NREQ-1:0]  m_res_valid = '0;
    logic [ROW_W-1:0] m_res_data = '0;
    bit               m_err = 1'b0;
    int unsigned      m_jobs[NREQ];
    int               qsize;
    bit               pop_now;

    task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner = -1; beats = 0; rr = 0; tags.delete(); rbeats = 0;
            m_res_valid = '0; m_res_data = '0; m_err = 1'b0;
            for (int i = 0; i < NREQ; i++) m_jobs[i] = 0;
        end else begin
            qsize   = tags.size();
            pop_now = bus.hsh_out_valid && qsize > 0 && rbeats == 4;
            m_res_valid = '0;
            if (bus.hsh_out_valid) begin
                m_res_data = bus.hsh_out_data;
                if (qsize == 0) m_err = 1'b1;
                else begin
                    m_res_valid[tags[0]] = 1'b1;
                    if (rbeats == 4) begin
                        m_jobs[tags[0]]++;
                        void'(tags.pop_front());
                        rbeats = 0;
                    end else rbeats++;
                end
            end
            if (owner < 0) begin
                if (bus.req_valid != '0 && (qsize < MAXI || pop_now)) begin
                    for (int k = 0; k < NREQ; k++)
                        if (owner < 0 && bus.req_valid[(rr + k) % NREQ]) owner = (rr + k) % NREQ;
                    rr = (owner + 1) % NREQ;
                    beats = 0;
                    tags.push_back(owner);
                end
            end else if (bus.req_valid[owner] && bus.hsh_gimme) begin
                beats++;
                if (beats == 5) owner = -1;
            end
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        logic            exp_hv;
        exp_rdy = '0;
        exp_hv  = 1'b0;
        if (rst_n && owner >= 0) begin
            exp_rdy[owner] = bus.hsh_gimme;
            exp_hv         = bus.req_valid[owner];
        end
        chk("req_ready", ROW_W'(bus.req_ready), ROW_W'(exp_rdy));
        chk("hsh_valid", ROW_W'(bus.hsh_valid), ROW_W'(exp_hv));
        if (exp_hv) chk("hsh_data", bus.hsh_data, bus.req_data[owner*ROW_W +: ROW_W]);
        chk("res_valid", ROW_W'(bus.res_valid), ROW_W'(m_res_valid));
        if (m_res_valid != '0 || !rst_n) chk("res_data", bus.res_data, m_res_data);
        chk("err_orphan", ROW_W'(bus.err_orphan), ROW_W'(m_err));
`ifdef SHA3_ARB_PERF_CNT_EN
        for (int g = 0; g < NREQ; g++) chk("perf_jobs", ROW_W'(bus.perf_jobs[g*32 +: 32]), ROW_W'(m_jobs[g]));
`endif
    end

    task automatic rand_row(output logic [ROW_W-1:0] r);
        for (int i = 0; i < ROW_W / 32; i++) r[i*32 +: 32] = $urandom();
    endtask

    task automatic rand_inputs_data();
        logic [ROW_W-1:0] r;
        for (int i = 0; i < NREQ; i++) begin
            rand_row(r);
            bus.req_data[i*ROW_W +: ROW_W] = r;
        end
        rand_row(r);
        bus.hsh_out_data = r;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0; bus.req_data = '0; bus.hsh_gimme = 1'b0;
        bus.hsh_out_valid = 1'b0; bus.hsh_out_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic cyc(output logic [NREQ-1:0] rdy, output logic [NREQ-1:0] rv, output logic e);
        @(negedge clk);
        rdy = bus.req_ready;
        rv  = bus.res_valid;
        e   = bus.err_orphan;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NREQ-1:0] r, v;
        logic            e, e0, e1, eall;
        logic [27:0]     pat;
        logic [23:0]     pat2;
        logic [NREQ-1:0] acc, v1;

        // Two requesters always valid: 0 then 1 then 0, 5 beats each, 1 idle cycle between.
        do_reset();
        rand_inputs_data();
        bus.req_valid = 2'b11;
        bus.hsh_gimme = 1'b1;
        pat = '0;
        for (int i = 0; i < 14; i++) begin
            cyc(r, v, e);
            pat = {pat[25:0], r};
        end
        chk("rr_pattern", ROW_W'(pat), ROW_W'(28'b00_01_01_01_01_01_00_10_10_10_10_10_00_01));

        // Fourth job fills the tag FIFO; the fifth grant waits until the first result pops.
        for (int i = 0; i < 10; i++) cyc(r, v, e);
        acc = '0;
        for (int i = 0; i < 6; i++) begin
            cyc(r, v, e);
            acc |= r;
        end
        chk("full_withhold", ROW_W'(acc), '0);
        bus.hsh_out_valid = 1'b1;
        pat2 = '0;
        for (int i = 0; i < 5; i++) begin
            rand_inputs_data();
            cyc(r, v, e);
            pat2 = {pat2[19:0], r, v};
        end
        bus.hsh_out_valid = 1'b0;
        cyc(r, v, e);
        pat2 = {pat2[19:0], r, v};
        chk("pop_grant", ROW_W'(pat2), ROW_W'(24'b0000_0001_0001_0001_0001_0101));

        // Orphan result beat: sticky error, no owner flagged.
        do_reset();
        rand_inputs_data();
        bus.hsh_out_valid = 1'b1;
        cyc(r, v, e0);
        bus.hsh_out_valid = 1'b0;
        cyc(r, v1, e1);
        chk("orphan_first", ROW_W'({e0, e1, v1}), ROW_W'(4'b0100));
        eall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(r, v, e);
            eall &= e;
        end
        chk("orphan_sticky", ROW_W'(eall), ROW_W'(1'b1));

        // Reset mid-job with two tags queued: outputs drop at once, tags are discarded.
        do_reset();
        rand_inputs_data();
        bus.req_valid = 2'b11;
        bus.hsh_gimme = 1'b1;
        for (int i = 0; i < 9; i++) cyc(r, v, e);
        chk("pre_reset_feed", ROW_W'({bus.req_ready, bus.hsh_valid}), ROW_W'(3'b101));
        rst_n = 1'b0;
        #1;
        chk("reset_async", ROW_W'({bus.req_ready, bus.hsh_valid, bus.res_valid, bus.err_orphan}), '0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.req_valid = 2'b01;
        bus.hsh_out_valid = 1'b1;
        cyc(r, v, e);
        bus.hsh_out_valid = 1'b0;
        cyc(r, v, e);
        chk("post_reset", ROW_W'({r, v, e}), ROW_W'(5'b01_00_1));

        // Randomized traffic with one asynchronous reset pulse in the middle.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 7) == 0) bus.req_valid[i] = ~bus.req_valid[i];
            rand_inputs_data();
            bus.hsh_gimme = ($urandom_range(0, 3) != 0);
            bus.hsh_out_valid = (tags.size() > 0) ? ($urandom_range(0, 2) == 0)
                                                  : ($urandom_range(0, 199) == 0);
            if (c == 1500) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/sha3_hasher_arbiter.md
SHA3_HASHER_ARBITER -- requirements
Module: sha3_hasher_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2: number of requesters sharing one iterative hasher, range 2..8.
REQ-002 SHALL have parameter ROW_W, default 320: width of one state row beat (5 lanes x 64 bits).
REQ-003 SHALL have parameter MAX_INFLIGHT, default 4: depth of the tag FIFO, which is also the maximum number of jobs inside the hasher.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid, input, NREQ bits: requester i presents a row beat.
REQ-007 SHALL have port req_data, input, NREQ*ROW_W bits: row beats; requester i occupies slice i.
REQ-008 SHALL have port req_ready, output, NREQ bits: beat accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port hsh_valid, output, 1 bit: row beat to the hasher.
REQ-010 SHALL have port hsh_data, output, ROW_W bits: row data to the hasher.
REQ-011 SHALL have port hsh_gimme, input, 1 bit: hasher can take a beat this cycle.
REQ-012 SHALL have port hsh_out_valid, input, 1 bit: hasher result beat valid.
REQ-013 SHALL have port hsh_out_data, input, ROW_W bits: hasher result beat.
REQ-014 SHALL have port res_valid, output, NREQ bits: one-hot; marks the result beat owner.
REQ-015 SHALL have port res_data, output, ROW_W bits: result beat, shared by all requesters.
REQ-016 SHALL have port err_orphan, output, 1 bit: sticky; set when a result beat arrives with the tag FIFO empty.

Function
REQ-017 A job SHALL be exactly 5 consecutive accepted beats from one requester, and a granted job SHALL NOT be interleaved with another requester's beats.
REQ-018 The FSM SHALL have states IDLE, FEED and HOLD.
REQ-019 IDLE: a grant SHALL be made when some req_valid is high and the tag FIFO is not full, or is full with a pop in the same cycle; the FSM then goes to FEED.
REQ-020 The grant SHALL be round-robin, searching from (last winner + 1) mod NREQ; after reset the search SHALL start at requester 0.
REQ-021 At grant the winner index SHALL be pushed to the tag FIFO.
REQ-022 FEED: hsh_valid SHALL equal req_valid[winner], hsh_data SHALL equal the winner's slice, and req_ready[winner] SHALL equal hsh_gimme (combinational, zero added latency).
REQ-023 FEED: all other req_ready bits SHALL be 0.
REQ-024 The beat counter SHALL count 0..4; on the 5th accepted beat the FSM SHALL return to IDLE, and the next grant is possible in the following cycle.
REQ-025 FEED with req_valid[winner] low SHALL go to HOLD; HOLD SHALL stall with hsh_valid 0 and return to FEED when req_valid[winner] rises.
REQ-026 The grant SHALL be kept through HOLD.
REQ-027 Result routing: each hsh_out_valid beat SHALL be registered one cycle onto res_data, and res_valid SHALL be one-hot at the FIFO head tag.
REQ-028 A 5-beat result counter SHALL pop the tag FIFO on the 5th result beat.
REQ-029 A result beat arriving with the tag FIFO empty SHALL set err_orphan, and res_valid SHALL stay 0 for that beat.
REQ-030 A push and a pop in the same cycle SHALL leave the FIFO count unchanged, including when the FIFO is full.
REQ-031 The FIFO pointers SHALL wrap modulo MAX_INFLIGHT.
REQ-032 req_valid deasserted by a non-winner SHALL have no effect.

Reset
REQ-033 Asserting rst_n low SHALL asynchronously force:
- FSM to IDLE;
- both counters to 0;
- FIFO to empty;
- RR pointer to 0;
- req_ready, hsh_valid, res_valid and err_orphan to 0;
- res_data to 0.
REQ-034 Reset mid-job SHALL discard the partial job and all in-flight tags; the hasher is reset externally alongside.
REQ-035 Deassertion SHALL be synchronised externally; the first grant is possible on the first edge after release.

Configuration
REQ-036 With SHA3_ARB_PERF_CNT_EN defined, the block SHALL add output perf_jobs (NREQ*32 bits): per-requester count of completed jobs (5th result beat routed), wrapping at 2^32, reset 0.
REQ-037 With SHA3_ARB_PERF_CNT_EN undefined, perf_jobs and its counters SHALL be absent, with no other change in behaviour.

Verification
REQ-038 Requesters 0 and 1 both valid continuously, hsh_gimme=1: grants alternate 0,1,0,1, each 5 beats in consecutive cycles, with 1 idle cycle between jobs.
REQ-039 Requester 1 drops req_valid after beat 2 for 3 cycles: hsh_valid=0 for 3 cycles, requester 0 is never granted, and the job resumes at beat 3.
REQ-040 Hasher outputs never return while 5 jobs are queued (MAX_INFLIGHT=4): the 5th grant is withheld, and it is granted in the cycle the first result's 5th beat pops.
REQ-041 Results for tags 1 then 0: res_valid = 2'b10 for 5 beats, then 2'b01 for 5 beats, each one cycle after hsh_out_valid.
REQ-042 hsh_out_valid pulses with the FIFO empty: err_orphan=1 from the next cycle until rst_n; res_valid stays 0.
REQ-043 rst_n low at FEED beat 3 with 2 tags queued: outputs are 0 immediately; after release, a grant goes to requester 0 and the first result beat routes nowhere and sets err_orphan.
